// File: rtl/operand_fetch_if.sv
// Bundle of the decode, register-file, writeback, flush and execute signals
// around the operand fetch stage.
interface operand_fetch_if;
    logic        dec_valid;
    logic        dec_ready;
    logic        dec_rden1;
    logic        dec_rden2;
    logic [4:0]  dec_raddr1;
    logic [4:0]  dec_raddr2;
    logic        dec_wren;
    logic [4:0]  dec_waddr;
    logic        rf_rden1;
    logic        rf_rden2;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_wren;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic        ex_wren;
    logic [4:0]  ex_waddr;

    modport slave (
        input  dec_valid, dec_rden1, dec_rden2, dec_raddr1, dec_raddr2,
               dec_wren, dec_waddr, rf_rdata1, rf_rdata2,
               wb_wren, wb_waddr, wb_wdata, flush, ex_ready,
        output dec_ready, rf_rden1, rf_rden2, rf_raddr1, rf_raddr2,
               ex_valid, ex_op1, ex_op2, ex_wren, ex_waddr
    );

    modport master (
        output dec_valid, dec_rden1, dec_rden2, dec_raddr1, dec_raddr2,
               dec_wren, dec_waddr, rf_rdata1, rf_rdata2,
               wb_wren, wb_waddr, wb_wdata, flush, ex_ready,
        input  dec_ready, rf_rden1, rf_rden2, rf_raddr1, rf_raddr2,
               ex_valid, ex_op1, ex_op2, ex_wren, ex_waddr
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboard-based RAW/WAW interlock, writeback bypass
// and a single registered operand bundle toward execute.
module operand_fetch (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);

    logic [31:0] pend_r;
    logic [31:0] pend_nxt_s;
    logic [31:0] epend_s;
    logic [31:0] wb_clr_s;
    logic [31:0] flush_clr_s;
    logic [31:0] acc_set_s;
    logic        stall_s;
    logic        dec_ready_s;
    logic        accept_s;
    logic [31:0] op1_s;
    logic [31:0] op2_s;

    logic        ex_valid_r;
    logic [31:0] ex_op1_r;
    logic [31:0] ex_op2_r;
    logic        ex_wren_r;
    logic [4:0]  ex_waddr_r;

    function automatic logic [31:0] onehot(input logic [4:0] addr);
        return 32'd1 << addr;
    endfunction

    // x0 reads as zero; a same-cycle writeback wins over the register file.
    function automatic logic [31:0] resolve_op(
        input logic        rden,
        input logic [4:0]  raddr,
        input logic [31:0] rf_rdata,
        input logic        wb_wren,
        input logic [4:0]  wb_waddr,
        input logic [31:0] wb_wdata
    );
        if (!rden || raddr == 5'd0) begin
            return 32'd0;
        end else if (wb_wren && wb_waddr == raddr) begin
            return wb_wdata;
        end else begin
            return rf_rdata;
        end
    endfunction

    assign bus.rf_rden1  = bus.dec_rden1;
    assign bus.rf_rden2  = bus.dec_rden2;
    assign bus.rf_raddr1 = bus.dec_raddr1;
    assign bus.rf_raddr2 = bus.dec_raddr2;
    assign bus.dec_ready = dec_ready_s;
    assign bus.ex_valid  = ex_valid_r;
    assign bus.ex_op1    = ex_op1_r;
    assign bus.ex_op2    = ex_op2_r;
    assign bus.ex_wren   = ex_wren_r;
    assign bus.ex_waddr  = ex_waddr_r;

    // Hazard detection, acceptance and next scoreboard state.
    always_comb begin
        epend_s = bus.wb_wren ? (pend_r & ~onehot(bus.wb_waddr)) : pend_r;

        stall_s = (bus.dec_rden1 && bus.dec_raddr1 != 5'd0 && epend_s[bus.dec_raddr1]) ||
                  (bus.dec_rden2 && bus.dec_raddr2 != 5'd0 && epend_s[bus.dec_raddr2]) ||
                  (bus.dec_wren  && bus.dec_waddr  != 5'd0 && epend_s[bus.dec_waddr]);

        dec_ready_s = !stall_s && !bus.flush && (!ex_valid_r || bus.ex_ready);
        accept_s    = bus.dec_valid && dec_ready_s;

        op1_s = resolve_op(bus.dec_rden1, bus.dec_raddr1, bus.rf_rdata1,
                           bus.wb_wren, bus.wb_waddr, bus.wb_wdata);
        op2_s = resolve_op(bus.dec_rden2, bus.dec_raddr2, bus.rf_rdata2,
                           bus.wb_wren, bus.wb_waddr, bus.wb_wdata);

        wb_clr_s    = (bus.wb_wren && bus.wb_waddr != 5'd0) ? onehot(bus.wb_waddr) : 32'd0;
        flush_clr_s = (bus.flush && ex_valid_r && ex_wren_r && ex_waddr_r != 5'd0) ?
                      onehot(ex_waddr_r) : 32'd0;
        acc_set_s   = (accept_s && bus.dec_wren && bus.dec_waddr != 5'd0) ?
                      onehot(bus.dec_waddr) : 32'd0;

        // Set applied last so a new producer outranks a same-cycle clear.
        pend_nxt_s = ((pend_r & ~wb_clr_s & ~flush_clr_s) | acc_set_s) & 32'hFFFF_FFFE;
    end

    // Pending-write scoreboard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r <= 32'd0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    // Operand bundle register toward execute.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_r <= 1'b0;
            ex_op1_r   <= 32'd0;
            ex_op2_r   <= 32'd0;
            ex_wren_r  <= 1'b0;
            ex_waddr_r <= 5'd0;
        end else if (bus.flush) begin
            ex_valid_r <= 1'b0;
        end else if (accept_s) begin
            ex_valid_r <= 1'b1;
            ex_op1_r   <= op1_s;
            ex_op2_r   <= op2_s;
            ex_wren_r  <= bus.dec_wren;
            ex_waddr_r <= bus.dec_waddr;
        end else if (bus.ex_ready) begin
            ex_valid_r <= 1'b0;
        end else begin
            ex_valid_r <= ex_valid_r;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, operand resolution, interlocks,
// backpressure, flush and mid-transfer reset.
module tb_operand_fetch;

    logic clk;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    operand_fetch_if b ();

    operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b.dec_valid  = 1'b0;
        b.dec_rden1  = 1'b0;
        b.dec_rden2  = 1'b0;
        b.dec_raddr1 = 5'd0;
        b.dec_raddr2 = 5'd0;
        b.dec_wren   = 1'b0;
        b.dec_waddr  = 5'd0;
        b.rf_rdata1  = 32'd0;
        b.rf_rdata2  = 32'd0;
        b.wb_wren    = 1'b0;
        b.wb_waddr   = 5'd0;
        b.wb_wdata   = 32'd0;
        b.flush      = 1'b0;
        b.ex_ready   = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #2;
        vectors++; if (b.ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ex_valid: got %b want 0", b.ex_valid); end
        vectors++; if (b.ex_op1 !== 32'd0) begin miscompares++; $display("FAIL reset_ex_op1: got %h want 0", b.ex_op1); end
        vectors++; if (b.ex_op2 !== 32'd0) begin miscompares++; $display("FAIL reset_ex_op2: got %h want 0", b.ex_op2); end
        vectors++; if (b.ex_wren !== 1'b0 || b.ex_waddr !== 5'd0) begin miscompares++; $display("FAIL reset_ex_w: got %b/%0d want 0/0", b.ex_wren, b.ex_waddr); end
        tick();
        rst = 1'b1;
        #1;
        vectors++; if (b.dec_ready !== 1'b1) begin miscompares++; $display("FAIL reset_dec_ready: got %b want 1", b.dec_ready); end
    endtask

    task automatic test_basic();
        idle();
        b.dec_valid = 1'b1;
        b.dec_rden1 = 1'b1; b.dec_raddr1 = 5'd5; b.rf_rdata1 = 32'h11;
        b.dec_rden2 = 1'b1; b.dec_raddr2 = 5'd6; b.rf_rdata2 = 32'h22;
        #1;
        vectors++; if (b.rf_rden1 !== 1'b1 || b.rf_raddr1 !== 5'd5) begin miscompares++; $display("FAIL basic_rf1: got %b/%0d want 1/5", b.rf_rden1, b.rf_raddr1); end
        vectors++; if (b.rf_rden2 !== 1'b1 || b.rf_raddr2 !== 5'd6) begin miscompares++; $display("FAIL basic_rf2: got %b/%0d want 1/6", b.rf_rden2, b.rf_raddr2); end
        vectors++; if (b.dec_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready: got %b want 1", b.dec_ready); end
        tick();
        vectors++; if (b.ex_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", b.ex_valid); end
        vectors++; if (b.ex_op1 !== 32'h11) begin miscompares++; $display("FAIL basic_op1: got %h want 00000011", b.ex_op1); end
        vectors++; if (b.ex_op2 !== 32'h22) begin miscompares++; $display("FAIL basic_op2: got %h want 00000022", b.ex_op2); end
        idle();
        tick();
        vectors++; if (b.ex_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain: got %b want 0", b.ex_valid); end
        vectors++; if (b.ex_op1 !== 32'h11) begin miscompares++; $display("FAIL basic_hold_op1: got %h want 00000011", b.ex_op1); end
    endtask

    task automatic test_raw_stall();
        idle();
        b.dec_valid = 1'b1; b.dec_wren = 1'b1; b.dec_waddr = 5'd7;
        tick();
        vectors++; if (b.ex_wren !== 1'b1 || b.ex_waddr !== 5'd7) begin miscompares++; $display("FAIL raw_producer: got %b/%0d want 1/7", b.ex_wren, b.ex_waddr); end
        idle();
        b.dec_valid = 1'b1; b.dec_rden1 = 1'b1; b.dec_raddr1 = 5'd7; b.rf_rdata1 = 32'h5555;
        #1;
        vectors++; if (b.dec_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall0: got %b want 0", b.dec_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (b.dec_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall_hold: got %b want 0 (cycle %0d)", b.dec_ready, i); end
        end
        vectors++; if (b.ex_valid !== 1'b0) begin miscompares++; $display("FAIL raw_bubble: got %b want 0", b.ex_valid); end
        b.wb_wren = 1'b1; b.wb_waddr = 5'd7; b.wb_wdata = 32'hABCD;
        #1;
        vectors++; if (b.dec_ready !== 1'b1) begin miscompares++; $display("FAIL raw_release: got %b want 1", b.dec_ready); end
        tick();
        vectors++; if (b.ex_valid !== 1'b1 || b.ex_op1 !== 32'hABCD) begin miscompares++; $display("FAIL raw_bypass: got %b/%h want 1/0000abcd", b.ex_valid, b.ex_op1); end
        idle();
        tick();
        b.dec_valid = 1'b1; b.dec_rden1 = 1'b1; b.dec_raddr1 = 5'd7;
        #1;
        vectors++; if (b.dec_ready !== 1'b1) begin miscompares++; $display("FAIL raw_cleared: got %b want 1", b.dec_ready); end
        idle();
        tick();
    endtask

    task automatic test_set_priority();
        idle();
        b.dec_valid = 1'b1; b.dec_wren = 1'b1; b.dec_waddr = 5'd4;
        b.dec_rden2 = 1'b1; b.dec_raddr2 = 5'd4; b.rf_rdata2 = 32'h99;
        b.wb_wren = 1'b1; b.wb_waddr = 5'd4; b.wb_wdata = 32'h44;
        #1;
        vectors++; if (b.dec_ready !== 1'b1) begin miscompares++; $display("FAIL prio_ready: got %b want 1", b.dec_ready); end
        tick();
        vectors++; if (b.ex_op2 !== 32'h44) begin miscompares++; $display("FAIL prio_bypass2: got %h want 00000044", b.ex_op2); end
        idle();
        b.dec_valid = 1'b1; b.dec_rden1 = 1'b1; b.dec_raddr1 = 5'd4;
        #1;
        vectors++; if (b.dec_ready !== 1'b0) begin miscompares++; $display("FAIL prio_set_wins: got %b want 0", b.dec_ready); end
        b.wb_wren = 1'b1; b.wb_waddr = 5'd4;
        tick();
        idle();
        tick();
    endtask

    task automatic test_x0();
        idle();
        b.dec_valid = 1'b1;
        b.dec_rden1 = 1'b1; b.dec_raddr1 = 5'd0; b.rf_rdata1 = 32'hFFFF_FFFF;
        b.dec_rden2 = 1'b0; b.dec_raddr2 = 5'd3; b.rf_rdata2 = 32'h1234;
        b.dec_wren = 1'b1; b.dec_waddr = 5'd0;
        tick();
        vectors++; if (b.ex_op1 !== 32'd0) begin miscompares++; $display("FAIL x0_op1: got %h want 0", b.ex_op1); end
        vectors++; if (b.ex_op2 !== 32'd0) begin miscompares++; $display("FAIL x0_op2_disabled: got %h want 0", b.ex_op2); end
        idle();
        b.dec_valid = 1'b1; b.dec_rden1 = 1'b1; b.dec_rden2 = 1'b1;
        #1;
        vectors++; if (b.dec_ready !== 1'b1) begin miscompares++; $display("FAIL x0_no_stall: got %b want 1", b.dec_ready); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        b.ex_ready = 1'b0;
        b.dec_valid = 1'b1; b.dec_rden1 = 1'b1; b.dec_raddr1 = 5'd1; b.rf_rdata1 = 32'hA1;
        tick();
        vectors++; if (b.ex_valid !== 1'b1 || b.ex_op1 !== 32'hA1) begin miscompares++; $display("FAIL bp_first: got %b/%h want 1/000000a1", b.ex_valid, b.ex_op1); end
        b.dec_raddr1 = 5'd2; b.rf_rdata1 = 32'hB2;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (b.dec_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready: got %b want 0 (cycle %0d)", b.dec_ready, i); end
            tick();
            vectors++; if (b.ex_valid !== 1'b1 || b.ex_op1 !== 32'hA1) begin miscompares++; $display("FAIL bp_stable: got %b/%h want 1/000000a1 (cycle %0d)", b.ex_valid, b.ex_op1, i); end
        end
        b.ex_ready = 1'b1;
        #1;
        vectors++; if (b.dec_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got %b want 1", b.dec_ready); end
        tick();
        vectors++; if (b.ex_valid !== 1'b1 || b.ex_op1 !== 32'hB2) begin miscompares++; $display("FAIL bp_no_bubble: got %b/%h want 1/000000b2", b.ex_valid, b.ex_op1); end
        idle();
        tick();
        vectors++; if (b.ex_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", b.ex_valid); end
    endtask

    task automatic test_flush();
        idle();
        b.ex_ready = 1'b0;
        b.dec_valid = 1'b1; b.dec_wren = 1'b1; b.dec_waddr = 5'd9;
        tick();
        vectors++; if (b.ex_valid !== 1'b1 || b.ex_waddr !== 5'd9) begin miscompares++; $display("FAIL flush_load: got %b/%0d want 1/9", b.ex_valid, b.ex_waddr); end
        b.dec_wren = 1'b0; b.dec_waddr = 5'd0;
        b.dec_rden1 = 1'b1; b.dec_raddr1 = 5'd9;
        b.flush = 1'b1;
        #1;
        vectors++; if (b.dec_ready !== 1'b0) begin miscompares++; $display("FAIL flush_block: got %b want 0", b.dec_ready); end
        tick();
        vectors++; if (b.ex_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", b.ex_valid); end
        b.flush = 1'b0;
        #1;
        vectors++; if (b.dec_ready !== 1'b1) begin miscompares++; $display("FAIL flush_unpend: got %b want 1", b.dec_ready); end
        tick();
        vectors++; if (b.ex_valid !== 1'b1) begin miscompares++; $display("FAIL flush_accept: got %b want 1", b.ex_valid); end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        b.ex_ready = 1'b0;
        b.dec_valid = 1'b1; b.dec_wren = 1'b1; b.dec_waddr = 5'd3;
        b.dec_rden1 = 1'b1; b.dec_raddr1 = 5'd1; b.rf_rdata1 = 32'h33;
        tick();
        vectors++; if (b.ex_valid !== 1'b1 || b.ex_op1 !== 32'h33) begin miscompares++; $display("FAIL rmid_load: got %b/%h want 1/00000033", b.ex_valid, b.ex_op1); end
        b.dec_wren = 1'b0; b.dec_waddr = 5'd0; b.dec_raddr1 = 5'd3;
        b.ex_ready = 1'b1;
        #1;
        vectors++; if (b.dec_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_stall: got %b want 0", b.dec_ready); end
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (b.ex_valid !== 1'b0 || b.ex_op1 !== 32'd0 || b.ex_op2 !== 32'd0) begin miscompares++; $display("FAIL rmid_clear_ops: got %b/%h/%h want 0/0/0", b.ex_valid, b.ex_op1, b.ex_op2); end
        vectors++; if (b.ex_wren !== 1'b0 || b.ex_waddr !== 5'd0) begin miscompares++; $display("FAIL rmid_clear_w: got %b/%0d want 0/0", b.ex_wren, b.ex_waddr); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (b.dec_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %b want 1", b.dec_ready); end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw_stall();
        test_set_priority();
        test_x0();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and register address width at 5 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 dec_valid  input  1  decode offers an instruction.
REQ-005 dec_ready  output  1  block accepts the offered instruction this cycle.
REQ-006 dec_rden1, dec_rden2  input  1 each  source operand enables.
REQ-007 dec_raddr1, dec_raddr2  input  5 each  source register addresses.
REQ-008 dec_wren  input  1  instruction writes a destination register.
REQ-009 dec_waddr  input  5  destination register address.
REQ-010 rf_rden1, rf_rden2  output  1 each  register file read enables.
REQ-011 rf_raddr1, rf_raddr2  output  5 each  register file read addresses.
REQ-012 rf_rdata1, rf_rdata2  input  32 each  register file read data, same cycle.
REQ-013 wb_wren  input  1  writeback write enable; same signal as the register file write port.
REQ-014 wb_waddr  input  5  writeback address.
REQ-015 wb_wdata  input  32  writeback data.
REQ-016 flush  input  1  discard the instruction held in the output register.
REQ-017 ex_valid  output  1  execute operand bundle valid.
REQ-018 ex_ready  input  1  execute consumes the bundle this cycle.
REQ-019 ex_op1, ex_op2  output  32 each  resolved operands.
REQ-020 ex_wren  output  1  registered copy of dec_wren.
REQ-021 ex_waddr  output  5  registered copy of dec_waddr.

Function
REQ-022 rf_rden1/2 and rf_raddr1/2 SHALL be combinational copies of dec_rden1/2 and dec_raddr1/2.
REQ-023 A 32-bit pending scoreboard SHALL exist; bit 0 SHALL never be set.
REQ-024 Effective pending (epend) SHALL be pend with bit wb_waddr cleared when wb_wren=1, within the same cycle.
REQ-025 stall SHALL be 1 when any of the following holds: dec_rden1 & raddr1!=0 & epend[raddr1]; dec_rden2 & raddr2!=0 & epend[raddr2]; dec_wren & waddr!=0 & epend[waddr].
REQ-026 dec_ready SHALL be !stall & !flush & (!ex_valid | ex_ready), and SHALL be independent of dec_valid.
REQ-027 An instruction is accepted when dec_valid & dec_ready; on acceptance the output register SHALL load on the next edge (latency 1 cycle).
REQ-028 Operand n SHALL resolve as follows: 0 if rden=0 or raddr=0; wb_wdata if wb_wren & wb_waddr=raddr; otherwise rf_rdata.
REQ-029 On acceptance with dec_wren=1 and waddr!=0, pend[waddr] SHALL be set; the set SHALL take priority over a same-cycle clear.
REQ-030 wb_wren with wb_waddr!=0 SHALL clear pend[wb_waddr]; a writeback to a non-pending register SHALL leave the scoreboard unchanged.
REQ-031 When ex_valid & ex_ready and nothing is accepted, ex_valid SHALL fall next cycle; when both happen together, the new bundle SHALL replace the old without a bubble.
REQ-032 When ex_valid=0 and nothing is accepted, the output register SHALL hold its value.
REQ-033 flush SHALL clear ex_valid next cycle and block acceptance that cycle.
REQ-034 If flush occurs while ex_valid & ex_wren & ex_waddr!=0, pend[ex_waddr] SHALL be cleared.
REQ-035 While ex_valid=1 and ex_ready=0, ex_op1, ex_op2, ex_wren and ex_waddr SHALL remain stable.

Reset
REQ-036 While rst=0: ex_valid=0, ex_op1=0, ex_op2=0, ex_wren=0, ex_waddr=0, pend=0, all asynchronously.
REQ-037 After reset release with ex_valid=0, dec_ready SHALL be 1 whenever flush=0.
REQ-038 A reset asserted mid-transfer SHALL drop the held bundle without any writeback side effect.

Verification
REQ-039 Basic case: accept rs1=5, rs2=6 with rf data 0x11/0x22 and ex_ready=1 -> next cycle ex_valid=1, ex_op1=0x11, ex_op2=0x22.
REQ-040 RAW stall: accept wren x7, then offer rs1=x7 -> dec_ready=0 until wb_wren x7 with data 0xABCD; in that cycle the instruction is accepted and ex_op1=0xABCD.
REQ-041 Register x0: rs1=0 with rf_rdata1=0xFFFFFFFF -> ex_op1=0; wren x0 -> no stall on a subsequent read of x0.
REQ-042 Backpressure: ex_ready=0 for 3 cycles -> dec_ready=0 and ex_* stable; ex_ready=1 with a new offer -> back-to-back transfer, no bubble.
REQ-043 Flush: ex_valid=1 holding wren x9, assert flush -> ex_valid=0 next cycle, pend[9]=0, a following read of x9 is not stalled.
REQ-044 Reset: assert rst=0 mid-stall with pend[3]=1 -> all outputs 0, pend=0, dec_ready=1 after release.
